// File: rtl/sub_div_pkg.sv
// Shared definitions for the repeated-subtraction divider:
// default operand width and the controller state encoding.
package sub_div_pkg;

   localparam int DEF_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sub_div_ctrl_if.sv
// Request/result bundle for the divider: the requester drives start
// and operands, the divider returns status and held results.
interface sub_div_ctrl_if
   import sub_div_pkg::*;
#(
   parameter int W = DEF_W
);

   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/sub_div_ctrl_sub8.sv
// Combinational subtractor: d = a - b (mod 2^W), c = borrow (a < b).
// An equal pair gives c = 0, so rem == divisor counts as one more step.
module sub8
   import sub_div_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         c,
   output logic [W-1:0] d
);

   // One extra bit on the left catches the borrow out of the MSB.
   assign {c, d} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/sub_div_ctrl.sv
// Unsigned divider by repeated subtraction. One subtraction per RUN
// cycle; the quotient counts successful subtractions, the first borrow
// ends the run and freezes the remainder. Divide-by-zero skips RUN.
module sub_div_ctrl
   import sub_div_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic           clk,
   input  logic           rst,
   sub_div_ctrl_if.slave  bus
);

   localparam logic [W-1:0] ONE = W'(1);

   state_t       state_reg;
   state_t       state_next;
   logic [W-1:0] rem_r;
   logic [W-1:0] dvs_r;
   logic [W-1:0] quot_reg;
   logic [W-1:0] rmd_reg;
   logic         dbz_reg;
   logic         borrow;
   logic [W-1:0] diff;
   logic         divisor_zero;

   assign divisor_zero = (bus.divisor == '0);

   sub8 #(.W(W)) u_sub8 (
      .a (rem_r),
      .b (dvs_r),
      .c (borrow),
      .d (diff)
   );

   // State register; reset always lands in IDLE, dropping any run in flight.
   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next state: start only matters in IDLE, RUN exits on the first borrow.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (bus.start) state_next = divisor_zero ? DONE : RUN;
         RUN:  if (borrow)    state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: capture operands on accept, subtract while RUN, hold results.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_r    <= '0;
         dvs_r    <= '0;
         quot_reg <= '0;
         rmd_reg  <= '0;
         dbz_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  if (divisor_zero) begin
                     quot_reg <= '1;
                     rmd_reg  <= bus.dividend;
                     dbz_reg  <= 1'b1;
                  end else begin
                     rem_r    <= bus.dividend;
                     dvs_r    <= bus.divisor;
                     quot_reg <= '0;
                     dbz_reg  <= 1'b0;
                  end
               end
            end
            RUN: begin
               if (!borrow) begin
                  rem_r    <= diff;
                  quot_reg <= quot_reg + ONE;
               end else begin
                  rmd_reg  <= rem_r;
               end
            end
            default: ;
         endcase
      end
   end

   // Status decodes straight from state, so reset clears them with it.
   assign bus.busy        = (state_reg != IDLE);
   assign bus.done        = (state_reg == DONE);
   assign bus.quotient    = quot_reg;
   assign bus.remainder   = rmd_reg;
   assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_sub_div_ctrl.sv
// Self-checking bench for sub_div_ctrl: table of operand/expected records,
// random vectors against a division model, plus hand sequences for
// start-during-RUN, reset abort and back-to-back requests.
module tb_sub_div_ctrl;
   import sub_div_pkg::*;

   localparam int W = 8;

   typedef struct {
      int a;
      int b;
      int q;
      int r;
      int z;
      int lat;
   } vec_t;

   typedef struct {
      int q;
      int r;
      int z;
      int lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   vec_t tbl[9];

   always #5 clk = ~clk;

   sub_div_ctrl_if #(.W(W)) bus ();

   sub_div_ctrl #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t model(input int a, input int b);
      exp_t e;
      if (b == 0) begin
         e.q = 255; e.r = a; e.z = 1; e.lat = 1;
      end else begin
         e.q = a / b; e.r = a % b; e.z = 0; e.lat = e.q + 2;
      end
      return e;
   endfunction

   function automatic vec_t mk(input int a, input int b, input int q,
                               input int r, input int z, input int lat);
      vec_t v;
      v.a = a; v.b = b; v.q = q; v.r = r; v.z = z; v.lat = lat;
      return v;
   endfunction

   // Drive a request at the falling edge, let one rising edge sample it.
   // On return the sampling edge has passed (latency count 1 point).
   task automatic start_op(input int a, input int b, input bit keep);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = W'(a);
      bus.divisor  = W'(b);
      tick();
      if (!keep) bus.start = 1'b0;
   endtask

   // Waits for done (bounded), compares against the scoreboard head,
   // then checks the pulse ended and results are still held in IDLE.
   // inj_k > 0 pulses start with inj_a/inj_b at that latency point.
   task automatic wait_done(input int inj_k, input int inj_a, input int inj_b);
      int   lat;
      int   busy_low;
      exp_t e;
      lat      = -1;
      busy_low = 0;
      for (int k = 1; k <= 300; k++) begin
         if (bus.done === 1'b1) begin
            lat = k;
            break;
         end
         if (bus.busy !== 1'b1) busy_low++;
         if (k == inj_k) begin
            bus.start    = 1'b1;
            bus.dividend = W'(inj_a);
            bus.divisor  = W'(inj_b);
            tick();
            bus.start = 1'b0;
         end else begin
            tick();
         end
      end
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 0, 1);
         return;
      end
      e = sb.pop_front();
      $display("op result q=%0d r=%0d dbz=%0d lat=%0d (exp q=%0d r=%0d dbz=%0d lat=%0d)",
               bus.quotient, bus.remainder, bus.div_by_zero, lat, e.q, e.r, e.z, e.lat);
      chk("latency", lat, e.lat);
      chk("quotient", int'(bus.quotient), e.q);
      chk("remainder", int'(bus.remainder), e.r);
      chk("div_by_zero", int'(bus.div_by_zero), e.z);
      chk("busy_while_running", busy_low, 0);
      chk("busy_at_done", int'(bus.busy), 1);
      tick();
      chk("done_one_cycle", int'(bus.done), 0);
      chk("busy_after_done", int'(bus.busy), 0);
      chk("quotient_held", int'(bus.quotient), e.q);
      chk("remainder_held", int'(bus.remainder), e.r);
   endtask

   initial begin
      exp_t e;
      int   a;
      int   b;
      int   done_seen;

      tbl[0] = mk(  1,   1,   1,  0, 0,   3);
      tbl[1] = mk( 37,  34,   1,  3, 0,   3);
      tbl[2] = mk(  2, 251,   0,  2, 0,   2);
      tbl[3] = mk(255,   1, 255,  0, 0, 257);
      tbl[4] = mk(255, 255,   1,  0, 0,   3);
      tbl[5] = mk( 24,   0, 255, 24, 1,   1);
      tbl[6] = mk(  0,   5,   0,  0, 0,   2);
      tbl[7] = mk(100,   7,  14,  2, 0,  16);
      tbl[8] = mk(  0,   0, 255,  0, 1,   1);

      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) tick();
      chk("reset_busy", int'(bus.busy), 0);
      chk("reset_done", int'(bus.done), 0);
      chk("reset_quotient", int'(bus.quotient), 0);
      chk("reset_remainder", int'(bus.remainder), 0);
      chk("reset_dbz", int'(bus.div_by_zero), 0);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven vectors
      for (int i = 0; i < 9; i++) begin
         $display("vec %0d: %0d / %0d", i, tbl[i].a, tbl[i].b);
         e.q = tbl[i].q; e.r = tbl[i].r; e.z = tbl[i].z; e.lat = tbl[i].lat;
         sb.push_back(e);
         start_op(tbl[i].a, tbl[i].b, 1'b0);
         wait_done(0, 0, 0);
      end

      // Random vectors against the division model
      for (int i = 0; i < 6; i++) begin
         a = int'($urandom_range(255, 0));
         b = int'($urandom_range(255, 1));
         $display("rnd %0d: %0d / %0d", i, a, b);
         sb.push_back(model(a, b));
         start_op(a, b, 1'b0);
         wait_done(0, 0, 0);
      end

      // start pulsed with 7/7 during RUN must be ignored
      $display("seq: 145 / 16 with 7/7 start during RUN");
      sb.push_back(model(145, 16));
      start_op(145, 16, 1'b0);
      wait_done(3, 7, 7);

      // Reset at RUN cycle 50 aborts with no done
      $display("seq: 200 / 1 aborted by reset");
      start_op(200, 1, 1'b0);
      repeat (49) tick();
      chk("abort_busy_before", int'(bus.busy), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_done", int'(bus.done), 0);
      chk("abort_quotient", int'(bus.quotient), 0);
      chk("abort_remainder", int'(bus.remainder), 0);
      chk("abort_dbz", int'(bus.div_by_zero), 0);
      done_seen = 0;
      for (int k = 0; k < 300; k++) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
         tick();
      end
      chk("abort_no_done", done_seen, 0);
      $display("seq: 4 / 2 after abort");
      sb.push_back(model(4, 2));
      start_op(4, 2, 1'b0);
      wait_done(0, 0, 0);

      // Back-to-back: start held high is taken on the first IDLE cycle
      $display("seq: back-to-back 10/3 then 8/2 with start held");
      sb.push_back(model(10, 3));
      start_op(10, 3, 1'b1);
      wait_done(0, 0, 0);
      bus.dividend = 8'd8;
      bus.divisor  = 8'd2;
      sb.push_back(model(8, 2));
      tick();
      bus.start = 1'b0;
      chk("b2b_accepted", int'(bus.busy), 1);
      wait_done(0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
